// File: rtl/apple1_paste_pkg.sv
// Shared types and helpers for the Apple-1 ASCII paste path.
// Holds presenter states, ASCII constants and the byte filter/mapper.
package apple1_paste_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_ACK,
        GAP
    } paste_state_t;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] DEL = 8'h7F;

    // Returns {drop, byte}. last_cr refers to the previous raw byte kept.
    function automatic logic [8:0] map_ascii(
        input logic [7:0] b,
        input logic       last_cr
    );
        logic       drop;
        logic [7:0] o;
        drop = 1'b0;
        o    = b;
        unique case (1'b1)
            (b == LF): begin
                drop = last_cr;
                o    = CR;
            end
            (b >= 8'h61 && b <= 8'h7A): o = b - 8'h20;
            (b == 8'h00 || b == DEL || b[7]): drop = 1'b1;
            (b == TAB): o = 8'h20;
            default: o = b;
        endcase
        return {drop, o};
    endfunction

endpackage

// File: rtl/paste_fifo.sv
// Single-clock FIFO with synchronous read (block-RAM style).
// Ports: push/din write, pop/dout read (dout valid next cycle), flush empties; full/empty/level status.
module paste_fifo #(
    parameter int AW = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [7:0]   din,
    input  logic         pop,
    input  logic         flush,
    output logic [7:0]   dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);

    localparam int         DEPTH = 1 << AW;
    localparam logic [AW:0] CAP  = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level == CAP);
    assign empty = (level == '0);

    // Flush first, then a same-cycle push lands in the emptied FIFO.
    assign wr_en = push && (flush || !full);
    assign rd_en = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[flush ? '0 : wr_ptr] <= din;
        if (rd_en)
            dout <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= AW'(wr_en);
            rd_ptr <= '0;
            level  <= (AW+1)'(wr_en);
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_en, rd_en})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ascii_paste.sv
// Buffers TXT download bytes, maps them to Apple-1 keys and paces them out.
// In: clk_sys, reset, ioctl_*, key_ack (+abort with ASCII_PASTE_ABORT_EN). Out: key_data/key_valid, busy, overflow, level.
module ascii_paste
    import apple1_paste_pkg::*;
#(
    parameter int         FIFO_AW   = 9,
    parameter int         CHAR_GAP  = 2500,
    parameter int         CR_GAP    = 250000,
    parameter logic [7:0] TXT_INDEX = 8'd0
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_download,
    input  logic [7:0]         ioctl_index,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_dout,
`ifdef ASCII_PASTE_ABORT_EN
    input  logic               abort,
`endif
    output logic [7:0]         key_data,
    output logic               key_valid,
    input  logic               key_ack,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   level
);

    localparam int GAP_MAX = (CR_GAP > CHAR_GAP) ? CR_GAP : CHAR_GAP;
    localparam int GW      = $clog2(GAP_MAX + 1);

    logic         sel;
    logic         dl_q;
    logic         dl_start;
    logic         accept;
    logic [8:0]   mapped;
    logic         keep;
    logic         last_cr;
    logic         push_q;
    logic [7:0]   push_d;
    logic         abort_i;
    logic         flush;
    logic         pop;
    logic [7:0]   fifo_q;
    logic         full;
    logic         empty;
    logic         cur_cr;
    logic [GW-1:0] gap_cnt;
    paste_state_t state;
    paste_state_t nstate;

`ifdef ASCII_PASTE_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign sel      = (ioctl_index == TXT_INDEX);
    assign dl_start = ioctl_download && !dl_q && sel;
    assign accept   = ioctl_wr && ioctl_download && sel;
    // A byte on the start edge is mapped as the first byte of the new file.
    assign mapped   = map_ascii(ioctl_dout, last_cr && !dl_start);
    assign keep     = accept && !mapped[8];
    assign flush    = dl_start || abort_i;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_q     <= 1'b0;
            last_cr  <= 1'b0;
            push_q   <= 1'b0;
            push_d   <= 8'h00;
            overflow <= 1'b0;
        end else begin
            dl_q   <= ioctl_download;
            push_q <= keep;
            push_d <= mapped[7:0];
            if (keep)
                last_cr <= (ioctl_dout == CR);
            else if (dl_start)
                last_cr <= 1'b0;
            if (dl_start)
                overflow <= 1'b0;
            else if (push_q && full && !flush)
                overflow <= 1'b1;
        end
    end

    paste_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk_sys),
        .rst   (reset),
        .push  (push_q),
        .din   (push_d),
        .pop   (pop),
        .flush (flush),
        .dout  (fifo_q),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        nstate = state;
        pop    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    pop    = 1'b1;
                    nstate = LOAD;
                end
            end
            LOAD:     nstate = WAIT_ACK;
            WAIT_ACK: if (key_ack) nstate = GAP;
            GAP:      if (gap_cnt == '0) nstate = IDLE;
            default:  nstate = IDLE;
        endcase
        if (abort_i) begin
            nstate = IDLE;
            pop    = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state     <= IDLE;
            key_data  <= 8'h00;
            key_valid <= 1'b0;
            gap_cnt   <= '0;
            cur_cr    <= 1'b0;
        end else begin
            state <= nstate;
            if (abort_i) begin
                key_valid <= 1'b0;
            end else begin
                unique case (state)
                    LOAD: begin
                        key_data  <= {1'b1, fifo_q[6:0]};
                        key_valid <= 1'b1;
                        cur_cr    <= (fifo_q == CR);
                    end
                    WAIT_ACK: begin
                        if (key_ack) begin
                            key_valid <= 1'b0;
                            gap_cnt   <= cur_cr ? GW'(CR_GAP) : GW'(CHAR_GAP);
                        end
                    end
                    GAP: begin
                        if (gap_cnt != '0)
                            gap_cnt <= gap_cnt - 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy = (level != '0) || (state != IDLE);

endmodule

// File: tb/tb_ascii_paste.sv
// Self-checking bench for ascii_paste: directed sequences plus random bytes.
// Expected characters come from a queue-based model of the mapping rules.
module tb_ascii_paste;

    localparam int AW   = 9;
    localparam int CG   = 10;
    localparam int CRG  = 100;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic [7:0]  key_data;
    logic        key_valid;
    logic        key_ack;
    logic        busy;
    logic        overflow;
    logic [AW:0] level;
`ifdef ASCII_PASTE_ABORT_EN
    logic        abort;
`endif

    int checks = 0;
    int errors = 0;
    int since_ack = 0;
    int taken = 0;
    bit gap_en = 0;
    bit prev_cr = 0;
    bit m_lc = 0;
    logic [7:0] q[$];

    always #5 clk_sys = ~clk_sys;

    ascii_paste #(
        .FIFO_AW   (AW),
        .CHAR_GAP  (CG),
        .CR_GAP    (CRG),
        .TXT_INDEX (8'd0)
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_dout     (ioctl_dout),
`ifdef ASCII_PASTE_ABORT_EN
        .abort          (abort),
`endif
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_ack        (key_ack),
        .busy           (busy),
        .overflow       (overflow),
        .level          (level)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
        since_ack++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of the keyboard mapping, written from the character rules.
    task automatic send(input logic [7:0] b);
        bit live;
        bit lower;
        bit junk;
        live  = ioctl_download && (ioctl_index == 8'd0);
        lower = (b >= 8'h61) && (b <= 8'h7A);
        junk  = (b == 8'h00) || (b >= 8'h7F);
        ioctl_wr   = 1'b1;
        ioctl_dout = b;
        tick();
        ioctl_wr   = 1'b0;
        if (live) begin
            if (b == 8'h0A) begin
                if (!m_lc) q.push_back(8'h0D);
            end else if (lower) begin
                q.push_back(b - 8'd32);
            end else if (b == 8'h09) begin
                q.push_back(8'h20);
            end else if (!junk) begin
                q.push_back(b);
            end
            if (!(junk || (b == 8'h0A && m_lc)))
                m_lc = (b == 8'h0D);
        end
    endtask

    task automatic start_dl();
        ioctl_download = 1'b0;
        tick();
        ioctl_index    = 8'd0;
        ioctl_download = 1'b1;
        tick();
        m_lc = 0;
    endtask

    task automatic wait_valid();
        int lim;
        lim = 0;
        while (key_valid !== 1'b1 && lim < 3000) begin
            tick();
            lim++;
        end
    endtask

    task automatic take(input string tag, input int hold);
        logic [7:0] e;
        int g;
        int need;
        wait_valid();
        g = since_ack;
        chk({tag, "_valid"}, 32'(key_valid), 32'd1);
        if (q.size() == 0) begin
            chk({tag, "_model_empty"}, 32'(q.size()), 32'd1);
            return;
        end
        e = q.pop_front();
        e = {1'b1, e[6:0]};
        chk(tag, 32'(key_data), 32'(e));
        if (gap_en) begin
            need = prev_cr ? CRG : CG;
            chk({tag, "_gap"}, 32'(g >= need + 1 && g <= need + 4), 32'd1);
        end
        prev_cr = (e == 8'h8D);
        repeat (hold) tick();
        key_ack = 1'b1;
        tick();
        since_ack = 0;
        key_ack = 1'b0;
        taken++;
        gap_en = 1;
    endtask

    task automatic drain(input string tag);
        while (q.size() > 0) take(tag, 0);
        repeat (CG + 10) tick();
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] sp [14] = '{8'h00, 8'h0A, 8'h0D, 8'h09, 8'h7F, 8'h80,
                                8'hFF, 8'h61, 8'h7A, 8'h60, 8'h7B, 8'h40,
                                8'h5A, 8'h0A};
        logic [7:0] d0;
        logic [7:0] hold_e;
        logic [AW:0] l0;
        bit stable;
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index = 8'd0;
        ioctl_wr = 1'b0;
        ioctl_dout = 8'h00;
        key_ack = 1'b0;
`ifdef ASCII_PASTE_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) tick();
        chk("rst_key_data", 32'(key_data), 32'h00);
        chk("rst_key_valid", 32'(key_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        reset = 1'b0;
        tick();

        // Foreign slot is ignored.
        ioctl_index = 8'd3;
        ioctl_download = 1'b1;
        tick();
        send(8'h41); send(8'h42); send(8'h43);
        repeat (3) tick();
        chk("idx_level", 32'(level), 32'd0);
        chk("idx_busy", 32'(busy), 32'd0);

        // "ab\r\nC"
        start_dl();
        gap_en = 0;
        send(8'h61); send(8'h62); send(8'h0D); send(8'h0A); send(8'h43);
        chk("t1_qsize", 32'(q.size()), 32'd4);
        drain("t1");

        // "X\nY"
        start_dl();
        gap_en = 0;
        send(8'h58); send(8'h0A); send(8'h59);
        chk("t2_qsize", 32'(q.size()), 32'd3);
        drain("t2");

        // Held character, then spurious ack in GAP.
        gap_en = 0;
        send(8'h50); send(8'h51);
        wait_valid();
        repeat (2) tick();
        d0 = key_data;
        l0 = level;
        stable = 1;
        repeat (10000) begin
            tick();
            if (key_data !== d0 || key_valid !== 1'b1 || level !== l0)
                stable = 0;
        end
        chk("hold_stable", 32'(stable), 32'd1);
        chk("hold_level", 32'(level), 32'd1);
        take("hold_p", 0);
        repeat (3) tick();
        key_ack = 1'b1;
        tick();
        key_ack = 1'b0;
        wait_valid();
        repeat (5) tick();
        chk("spur_valid", 32'(key_valid), 32'd1);
        gap_en = 0;
        take("spur_q", 0);

        // Random bytes with idle gaps and random ack delay.
        start_dl();
        gap_en = 0;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 9) < 4)
                send(sp[$urandom_range(0, 13)]);
            else
                send(8'($urandom_range(8'h20, 8'h7E)));
            repeat ($urandom_range(0, 2)) tick();
        end
        while (q.size() > 0) take("rnd", $urandom_range(0, 4));
        repeat (CRG + 10) tick();
        chk("rnd_busy", 32'(busy), 32'd0);

        // Overflow: one char on key_valid, 512 queued, last byte dropped.
        start_dl();
        gap_en = 0;
        for (int i = 0; i < 514; i++)
            send(8'h41 + 8'(i % 26));
        repeat (3) tick();
        chk("ovf_level", 32'(level), 32'd512);
        chk("ovf_flag", 32'(overflow), 32'd1);
        void'(q.pop_back());
        taken = 0;
        drain("ovf");
        chk("ovf_count", 32'(taken), 32'd513);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset while a char is held and five are queued.
        gap_en = 0;
        for (int i = 0; i < 6; i++)
            send(8'h30 + 8'(i));
        wait_valid();
        repeat (2) tick();
        chk("rstm_level_pre", 32'(level), 32'd5);
        reset = 1'b1;
        tick();
        chk("rstm_valid", 32'(key_valid), 32'd0);
        chk("rstm_level", 32'(level), 32'd0);
        chk("rstm_busy", 32'(busy), 32'd0);
        chk("rstm_overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        q.delete();
        m_lc = 0;
        repeat (3) tick();

        // New download edge flushes the queued remainder.
        gap_en = 0;
        for (int i = 0; i < 25; i++)
            send(8'h61 + 8'(i % 26));
        wait_valid();
        repeat (3) tick();
        chk("fl_level_pre", 32'(level), 32'd24);
        hold_e = q[0];
        start_dl();
        chk("fl_level", 32'(level), 32'd0);
        q.delete();
        q.push_back(hold_e);
        send(8'h4E); send(8'h45); send(8'h57);
        drain("fl");

`ifdef ASCII_PASTE_ABORT_EN
        gap_en = 0;
        for (int i = 0; i < 6; i++)
            send(8'h41 + 8'(i));
        wait_valid();
        repeat (2) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", 32'(key_valid), 32'd0);
        chk("ab_level", 32'(level), 32'd0);
        q.delete();
        tick();
        chk("ab_busy", 32'(busy), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
